ts_sync_aligner: RTL and testbench

TS_SYNC_ALIGNER -- requirements
Module: ts_sync_aligner

---
 rtl/ts_pkg.sv | 22 ++
 rtl/ts_sync_aligner_if.sv | 29 ++
 rtl/ts_sync_aligner.sv | 175 +++++++++++++++++
 tb/tb_ts_sync_aligner.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ts_pkg.sv
// ts_pkg
// Purpose: constants and types shared by the TS sync aligner and the downstream
//          replacer stage, so both agree on the packet size and the sync byte.
// Contents: TS_PACK_BYTE_SIZE, TS_SYNC_BYTE, the aligner state type and a
//           byte-position increment helper that wraps at the packet boundary.
package ts_pkg;

  localparam int         TS_PACK_BYTE_SIZE = 188;
  localparam logic [7:0] TS_SYNC_BYTE      = 8'h47;
  localparam logic [7:0] TS_LAST_POS       = 8'(TS_PACK_BYTE_SIZE - 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } ts_state_e;

  function automatic logic [7:0] ts_pos_inc(input logic [7:0] pos);
    return (pos == TS_LAST_POS) ? 8'd0 : pos + 8'd1;
  endfunction

endpackage

// File: rtl/ts_sync_aligner_if.sv
// ts_sync_aligner_if
// Purpose: byte-stream bundle between the front end, the sync aligner and the
//          replacer stage.
// Signals:
//   raw_data   [7:0]  unaligned TS byte from the front end
//   raw_valid         raw_data qualifier, one byte per cycle when high
//   mpeg_data  [7:0]  aligned byte to the replacer stage
//   mpeg_valid        mpeg_data qualifier
//   mpeg_sync         high on the packet-start byte only
// Modports: master = stream source / observer, slave = the aligner.
interface ts_sync_aligner_if;

  logic [7:0] raw_data;
  logic       raw_valid;
  logic [7:0] mpeg_data;
  logic       mpeg_valid;
  logic       mpeg_sync;

  modport master (
    output raw_data, raw_valid,
    input  mpeg_data, mpeg_valid, mpeg_sync
  );

  modport slave (
    input  raw_data, raw_valid,
    output mpeg_data, mpeg_valid, mpeg_sync
  );

endinterface

// File: rtl/ts_sync_aligner.sv
// ts_sync_aligner
// Purpose: finds 188-byte TS packet alignment in a raw byte stream, locks after
//          LOCK_COUNT consecutive sync bytes, drops lock after UNLOCK_COUNT
//          consecutive missing syncs, and forwards aligned bytes with a
//          packet-start marker. All outputs are registered (1-cycle latency).
// Ports:
//   mpeg_clk         sole clock, rising edge
//   mpeg_reset       asynchronous active-high reset
//   bus (slave)      raw_* in, mpeg_* out (see ts_sync_aligner_if)
//   locked           high while in LOCKED
//   packet_count     forwarded packet starts since reset, wraps
//   sync_loss_count  LOCKED->HUNT transitions since reset, saturates
//
// state  | meaning
// HUNT   | searching every valid byte for a sync byte candidate
// VERIFY | candidate found, checking for sync at each 188-byte boundary
// LOCKED | aligned; forwarding bytes, counting missed syncs
module ts_sync_aligner
  import ts_pkg::*;
#(
  parameter int LOCK_COUNT   = 3,
  parameter int UNLOCK_COUNT = 3
) (
  input  logic                mpeg_clk,
  input  logic                mpeg_reset,
  ts_sync_aligner_if.slave    bus,
  output logic                locked,
  output logic [31:0]         packet_count,
  output logic [15:0]         sync_loss_count
);

  localparam logic [3:0] LOCK_CNT   = 4'(LOCK_COUNT);
  localparam logic [3:0] UNLOCK_CNT = 4'(UNLOCK_COUNT);

  ts_state_e   r_state, w_state_nxt;
  logic [7:0]  r_pos, w_pos_nxt;
  logic [3:0]  r_hits, w_hits_nxt;
  logic [3:0]  r_misses, w_misses_nxt;

  logic [7:0]  r_mpeg_data;
  logic        r_mpeg_valid;
  logic        r_mpeg_sync;
  logic        r_locked;
  logic [31:0] r_packet_count;
  logic [15:0] r_sync_loss_count;

  logic        w_fwd;
  logic        w_sync;
  logic        w_loss;
  logic        w_is_sync;
  logic        w_at_start;
  logic [3:0]  w_hits_inc;
  logic [3:0]  w_misses_inc;

  always_comb begin
    w_state_nxt  = r_state;
    w_pos_nxt    = r_pos;
    w_hits_nxt   = r_hits;
    w_misses_nxt = r_misses;
    w_fwd        = 1'b0;
    w_sync       = 1'b0;
    w_loss       = 1'b0;
    w_is_sync    = (bus.raw_data == TS_SYNC_BYTE);
    w_at_start   = (r_pos == 8'd0);
    w_hits_inc   = r_hits + 4'd1;
    w_misses_inc = r_misses + 4'd1;

    if (bus.raw_valid) begin
      case (r_state)
        HUNT: begin
          if (w_is_sync) begin
            w_state_nxt = VERIFY;
            w_pos_nxt   = 8'd1;
            w_hits_nxt  = 4'd1;
          end
        end

        VERIFY: begin
          w_pos_nxt = ts_pos_inc(r_pos);
          if (w_at_start) begin
            if (w_is_sync) begin
              w_hits_nxt = w_hits_inc;
              // The byte completing verification is itself the first forwarded sync.
              if (w_hits_inc == LOCK_CNT) begin
                w_state_nxt  = LOCKED;
                w_misses_nxt = 4'd0;
                w_fwd        = 1'b1;
                w_sync       = 1'b1;
              end
            end else begin
              // Failed boundary byte is discarded, not re-examined as a candidate.
              w_state_nxt = HUNT;
              w_pos_nxt   = 8'd0;
              w_hits_nxt  = 4'd0;
            end
          end
        end

        LOCKED: begin
          w_pos_nxt = ts_pos_inc(r_pos);
          w_fwd     = 1'b1;
          w_sync    = w_at_start;
          if (w_at_start) begin
            if (w_is_sync) begin
              w_misses_nxt = 4'd0;
            end else if (w_misses_inc == UNLOCK_CNT) begin
              // The unlocking byte is swallowed.
              w_state_nxt  = HUNT;
              w_pos_nxt    = 8'd0;
              w_hits_nxt   = 4'd0;
              w_misses_nxt = 4'd0;
              w_fwd        = 1'b0;
              w_sync       = 1'b0;
              w_loss       = 1'b1;
            end else begin
              w_misses_nxt = w_misses_inc;
            end
          end
        end

        default: begin
          w_state_nxt = HUNT;
          w_pos_nxt   = 8'd0;
          w_hits_nxt  = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge mpeg_clk or posedge mpeg_reset) begin
    if (mpeg_reset) begin
      r_state  <= HUNT;
      r_pos    <= 8'd0;
      r_hits   <= 4'd0;
      r_misses <= 4'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_pos    <= w_pos_nxt;
      r_hits   <= w_hits_nxt;
      r_misses <= w_misses_nxt;
    end
  end

  always_ff @(posedge mpeg_clk or posedge mpeg_reset) begin
    if (mpeg_reset) begin
      r_mpeg_data       <= 8'd0;
      r_mpeg_valid      <= 1'b0;
      r_mpeg_sync       <= 1'b0;
      r_locked          <= 1'b0;
      r_packet_count    <= 32'd0;
      r_sync_loss_count <= 16'd0;
    end else begin
      r_mpeg_valid <= w_fwd;
      r_mpeg_sync  <= w_sync;
      r_locked     <= (w_state_nxt == LOCKED);
      if (w_fwd) begin
        r_mpeg_data <= bus.raw_data;
      end
      if (w_fwd && w_sync) begin
        r_packet_count <= r_packet_count + 32'd1;
      end
      if (w_loss && (r_sync_loss_count != 16'hFFFF)) begin
        r_sync_loss_count <= r_sync_loss_count + 16'd1;
      end
    end
  end

  assign bus.mpeg_data    = r_mpeg_data;
  assign bus.mpeg_valid   = r_mpeg_valid;
  assign bus.mpeg_sync    = r_mpeg_sync;
  assign locked           = r_locked;
  assign packet_count     = r_packet_count;
  assign sync_loss_count  = r_sync_loss_count;

endmodule

// File: tb/tb_ts_sync_aligner.sv
// tb_ts_sync_aligner
// Purpose: randomized scoreboard bench for ts_sync_aligner. The driver pushes
//          the expected registered response of every driven cycle; a monitor
//          pops and compares one entry per clock after the sampling edge.
module tb_ts_sync_aligner;

  localparam int LOCK_COUNT   = 3;
  localparam int UNLOCK_COUNT = 3;
  localparam int PKT          = 188;

  logic        mpeg_clk   = 1'b0;
  logic        mpeg_reset = 1'b0;
  logic        locked;
  logic [31:0] packet_count;
  logic [15:0] sync_loss_count;

  ts_sync_aligner_if u_if ();

  ts_sync_aligner #(
    .LOCK_COUNT  (LOCK_COUNT),
    .UNLOCK_COUNT(UNLOCK_COUNT)
  ) dut (
    .mpeg_clk       (mpeg_clk),
    .mpeg_reset     (mpeg_reset),
    .bus            (u_if),
    .locked         (locked),
    .packet_count   (packet_count),
    .sync_loss_count(sync_loss_count)
  );

  always #5 mpeg_clk = ~mpeg_clk;

  typedef struct {
    bit        fwd;
    bit [7:0]  data;
    bit        sync;
    bit        lck;
    bit [31:0] pc;
    bit [15:0] loss;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: alignment tracked as an anchor index in the valid-byte
  // sequence; a byte is a packet start when its distance from the anchor is a
  // multiple of the packet size.
  int        m_mode;   // 0 hunting, 1 verifying, 2 locked
  int        m_n;
  int        m_anchor;
  int        m_good;
  int        m_bad;
  bit [31:0] m_pc;
  int        m_loss;

  function automatic void model_reset();
    m_mode = 0; m_n = 0; m_anchor = 0; m_good = 0; m_bad = 0; m_pc = 0; m_loss = 0;
  endfunction

  function automatic exp_t model_step(bit v, bit [7:0] b);
    exp_t e;
    bit   start;
    e.fwd = 0; e.data = b; e.sync = 0;
    if (v) begin
      start = (((m_n - m_anchor) % PKT) == 0);
      if (m_mode == 0) begin
        if (b == 8'h47) begin
          m_mode = 1; m_anchor = m_n; m_good = 1;
        end
      end else if (m_mode == 1) begin
        if (start) begin
          if (b == 8'h47) begin
            m_good++;
            if (m_good == LOCK_COUNT) begin
              m_mode = 2; m_bad = 0; e.fwd = 1; e.sync = 1;
            end
          end else begin
            m_mode = 0;
          end
        end
      end else begin
        e.fwd = 1; e.sync = start;
        if (start) begin
          if (b == 8'h47) m_bad = 0;
          else begin
            m_bad++;
            if (m_bad == UNLOCK_COUNT) begin
              m_mode = 0; e.fwd = 0; e.sync = 0;
              if (m_loss != 65535) m_loss++;
            end
          end
        end
      end
      m_n++;
      if (e.fwd && e.sync) m_pc++;
    end
    e.lck  = (m_mode == 2);
    e.pc   = m_pc;
    e.loss = 16'(m_loss);
    return e;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: one expected entry per sampled cycle.
  always @(posedge mpeg_clk) begin
    exp_t e;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("mpeg_valid", 32'(u_if.mpeg_valid), 32'(e.fwd));
      if (e.fwd) begin
        chk("mpeg_data", 32'(u_if.mpeg_data), 32'(e.data));
        chk("mpeg_sync", 32'(u_if.mpeg_sync), 32'(e.sync));
      end else begin
        chk("mpeg_sync_idle", 32'(u_if.mpeg_sync), 32'd0);
      end
      chk("locked", 32'(locked), 32'(e.lck));
      chk("packet_count", packet_count, e.pc);
      chk("sync_loss_count", 32'(sync_loss_count), 32'(e.loss));
    end else begin
      chk("idle_valid", 32'(u_if.mpeg_valid), 32'd0);
    end
  end

  function automatic bit [7:0] payload();
    bit [7:0] x;
    x = 8'($urandom_range(0, 255));
    if (x == 8'h47) x = 8'h46;
    return x;
  endfunction

  task automatic drive(bit v, bit [7:0] b);
    @(negedge mpeg_clk);
    u_if.raw_valid = v;
    u_if.raw_data  = b;
    exp_q.push_back(model_step(v, b));
  endtask

  // gap: 0 none, 1 idle cycle after every byte, 2 random idle cycles
  task automatic send_packet(bit [7:0] sb, int gap, int nbytes = PKT);
    for (int i = 0; i < nbytes; i++) begin
      drive(1'b1, (i == 0) ? sb : payload());
      if (gap == 1 || (gap == 2 && $urandom_range(0, 2) == 0)) drive(1'b0, payload());
    end
  endtask

  task automatic drain();
    drive(1'b0, 8'h00);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(posedge mpeg_clk);
      #3;
    end
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_mpeg_data"},  32'(u_if.mpeg_data), 32'd0);
    chk({tag, "_mpeg_valid"}, 32'(u_if.mpeg_valid), 32'd0);
    chk({tag, "_mpeg_sync"},  32'(u_if.mpeg_sync), 32'd0);
    chk({tag, "_locked"},     32'(locked), 32'd0);
    chk({tag, "_pc"},         packet_count, 32'd0);
    chk({tag, "_loss"},       32'(sync_loss_count), 32'd0);
  endtask

  initial begin
    u_if.raw_valid = 1'b0;
    u_if.raw_data  = 8'h00;
    model_reset();
    #1 mpeg_reset = 1'b1;
    #1 check_reset_outputs("reset");
    repeat (2) @(negedge mpeg_clk);
    mpeg_reset = 1'b0;

    // Junk prefix, then aligned packets.
    for (int i = 0; i < 20; i++) drive(1'b1, payload());
    for (int p = 0; p < 5; p++) send_packet(8'h47, 0);
    drain();
    chk("A_locked", 32'(locked), 32'd1);
    chk("A_pc", packet_count, 32'd3);

    // Two corrupt syncs keep lock.
    for (int p = 0; p < 2; p++) send_packet(8'h00, 0);
    for (int p = 0; p < 2; p++) send_packet(8'h47, 0);
    drain();
    chk("B_locked", 32'(locked), 32'd1);
    chk("B_loss", 32'(sync_loss_count), 32'd0);
    chk("B_pc", packet_count, 32'd7);

    // Three corrupt syncs lose lock; relock after three good syncs.
    for (int p = 0; p < 3; p++) send_packet(8'h00, 0);
    drain();
    chk("C_unlocked", 32'(locked), 32'd0);
    chk("C_loss", 32'(sync_loss_count), 32'd1);
    for (int p = 0; p < 4; p++) send_packet(8'h47, 0);
    drain();
    chk("C_relocked", 32'(locked), 32'd1);
    chk("C_pc", packet_count, 32'd11);

    // raw_valid toggling every cycle while locked.
    for (int p = 0; p < 3; p++) send_packet(8'h47, 1);
    drain();
    chk("D_locked", 32'(locked), 32'd1);
    chk("D_pc", packet_count, 32'd14);

    // Reset mid-packet at byte 100.
    send_packet(8'h47, 0, 100);
    @(negedge mpeg_clk);
    chk("E_pre_locked", 32'(locked), 32'd1);
    u_if.raw_valid = 1'b0;
    mpeg_reset     = 1'b1;
    #1 check_reset_outputs("E_reset");
    model_reset();
    repeat (2) @(negedge mpeg_clk);
    mpeg_reset = 1'b0;
    for (int p = 0; p < 4; p++) send_packet(8'h47, 0);
    drain();
    chk("E_locked", 32'(locked), 32'd1);
    chk("E_pc", packet_count, 32'd2);

    // Random corruption with random idle gaps, checked by the model only.
    for (int p = 0; p < 12; p++) begin
      send_packet(($urandom_range(0, 3) == 0) ? 8'h00 : 8'h47, 2);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
